// File: rtl/lstm_h_history_if.sv
// Bus bundle for the LSTM hidden-state history buffer.
// master : the datapath side (drives write/read requests, observes the read vector and status).
// slave  : the buffer itself.
// Signals:
//   i, wr              - value to store and its write strobe
//   seq_start          - start a new sequence
//   bwd_start          - load the backward (BPTT) read pointer
//   rd, rd_mode, rd_slot - read request; mode 0 = slot rd_slot, mode 1 = backward pointer
//   o, o_valid         - read vector (unit 0 in the LSBs) and its one-cycle pulse
//   wr_ts, full, bptt_done, overflow - status
interface lstm_h_history_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_LSTM = 2,
  parameter int SLOT_W   = 4
);
  logic signed [WIDTH-1:0]    i;
  logic                       wr;
  logic                       seq_start;
  logic                       bwd_start;
  logic                       rd;
  logic                       rd_mode;
  logic [SLOT_W-1:0]          rd_slot;
  logic [NUM_LSTM*WIDTH-1:0]  o;
  logic                       o_valid;
  logic [SLOT_W-1:0]          wr_ts;
  logic                       full;
  logic                       bptt_done;
  logic                       overflow;

  modport master (
    output i, wr, seq_start, bwd_start, rd, rd_mode, rd_slot,
    input  o, o_valid, wr_ts, full, bptt_done, overflow
  );

  modport slave (
    input  i, wr, seq_start, bwd_start, rd, rd_mode, rd_slot,
    output o, o_valid, wr_ts, full, bptt_done, overflow
  );
endinterface

// File: rtl/lstm_h_history.sv
// Hidden-state history buffer for the LSTM datapath.
// Holds h_t for NUM_LSTM units over TIMESTEP steps plus slot 0 (h_{-1}).
// The forward pass writes one unit per beat through auto-advancing pointers;
// reads return a whole NUM_LSTM-wide slot one cycle later, addressed either
// directly or through a self-decrementing backward pointer.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - lstm_h_history_if.slave (write/read requests, read vector, status)
module lstm_h_history #(
  parameter int                      WIDTH    = 32,
  parameter int                      NUM_LSTM = 2,
  parameter int                      TIMESTEP = 7,
  parameter int                      SLOT_W   = 4,
  parameter logic signed [WIDTH-1:0] INIT     = '0,
  parameter bit                      CARRY    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  lstm_h_history_if.slave   bus
);

  localparam int DEPTH  = NUM_LSTM * (TIMESTEP + 1);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int UNIT_W = (NUM_LSTM > 1) ? $clog2(NUM_LSTM) : 1;
  localparam logic [SLOT_W-1:0] TS_LAST   = SLOT_W'(TIMESTEP);
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(NUM_LSTM - 1);

  logic signed [WIDTH-1:0]   mem_q [DEPTH];
  logic [SLOT_W-1:0]         wr_ts_q, wr_ts_d;
  logic [UNIT_W-1:0]         wr_unit_q, wr_unit_d;
  logic [SLOT_W-1:0]         bwd_ptr_q, bwd_ptr_d;
  logic                      full_q, full_d;
  logic                      bptt_done_q, bptt_done_d;
  logic                      overflow_q, overflow_d;
  logic                      o_valid_q, o_valid_d;
  logic [NUM_LSTM*WIDTH-1:0] o_q, o_d;
  logic [SLOT_W-1:0]         rd_sel;
  logic                      wr_en;
  logic                      carry_en;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [SLOT_W-1:0] slot, input int unit);
    return ADDR_W'(int'(slot) * NUM_LSTM + unit);
  endfunction

  // seq_start swallows a same-cycle write; a write while full is discarded.
  assign wr_en    = bus.wr && !bus.seq_start && !full_q;
  assign carry_en = CARRY && bus.seq_start && full_q;
  assign rd_sel   = bus.rd_mode ? bwd_ptr_q : bus.rd_slot;

  always_comb begin
    wr_ts_d     = wr_ts_q;
    wr_unit_d   = wr_unit_q;
    bwd_ptr_d   = bwd_ptr_q;
    full_d      = full_q;
    bptt_done_d = bptt_done_q;
    overflow_d  = overflow_q;
    o_valid_d   = 1'b0;
    o_d         = o_q;

    // Read samples the registered memory, so a same-cycle write or carry copy
    // into the addressed word is seen only by the next read.
    if (bus.rd) begin
      o_valid_d = 1'b1;
      for (int u = 0; u < NUM_LSTM; u++) begin
        o_d[u*WIDTH +: WIDTH] = (int'(rd_sel) > TIMESTEP) ? '0 : mem_q[word_addr(rd_sel, u)];
      end
    end

    // A pointer load takes precedence over the post-read decrement; the read
    // itself already used the old pointer through rd_sel.
    if (bus.bwd_start) begin
      bwd_ptr_d   = full_q ? TS_LAST : wr_ts_q - SLOT_W'(1);
      bptt_done_d = 1'b0;
    end else if (bus.rd && bus.rd_mode) begin
      if (bwd_ptr_q != '0) begin
        bwd_ptr_d = bwd_ptr_q - SLOT_W'(1);
      end else begin
        bptt_done_d = 1'b1;
      end
    end

    if (bus.seq_start) begin
      wr_ts_d     = SLOT_W'(1);
      wr_unit_d   = '0;
      full_d      = 1'b0;
      bptt_done_d = 1'b0;
    end else if (bus.wr) begin
      if (full_q) begin
        overflow_d = 1'b1;
      end else if (wr_unit_q == UNIT_LAST) begin
        wr_unit_d = '0;
        if (wr_ts_q == TS_LAST) begin
          full_d = 1'b1;
        end else begin
          wr_ts_d = wr_ts_q + SLOT_W'(1);
        end
      end else begin
        wr_unit_d = wr_unit_q + UNIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ts_q     <= SLOT_W'(1);
      wr_unit_q   <= '0;
      bwd_ptr_q   <= '0;
      full_q      <= 1'b0;
      bptt_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      o_valid_q   <= 1'b0;
      o_q         <= '0;
    end else begin
      wr_ts_q     <= wr_ts_d;
      wr_unit_q   <= wr_unit_d;
      bwd_ptr_q   <= bwd_ptr_d;
      full_q      <= full_d;
      bptt_done_q <= bptt_done_d;
      overflow_q  <= overflow_d;
      o_valid_q   <= o_valid_d;
      o_q         <= o_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= (k < NUM_LSTM) ? INIT : '0;
      end
    end else if (carry_en) begin
      // Whole last slot becomes the next sequence's h_{-1} in one cycle.
      for (int u = 0; u < NUM_LSTM; u++) begin
        mem_q[u] <= mem_q[TIMESTEP*NUM_LSTM + u];
      end
    end else if (wr_en) begin
      mem_q[word_addr(wr_ts_q, int'(wr_unit_q))] <= bus.i;
    end
  end

  assign bus.o         = o_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.wr_ts     = wr_ts_q;
  assign bus.full      = full_q;
  assign bus.bptt_done = bptt_done_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_lstm_h_history.sv
// Bench for lstm_h_history: two instances (CARRY=0 and CARRY=1) share one
// stimulus stream and are compared every cycle against a word-count based model,
// plus directed table and sequence checks with constant expectations.
module tb_lstm_h_history;
  localparam int W = 32;
  localparam int N = 2;
  localparam int T = 7;
  localparam int SW = 4;
  localparam logic [31:0] INITV = 32'h0000_1000;
  localparam logic [63:0] INIT_VEC = 64'h0000_1000_0000_1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [W-1:0] i_s;
  logic wr_s, ss_s, bs_s, rd_s, rm_s;
  logic [SW-1:0] slot_s;

  lstm_h_history_if #(.WIDTH(W), .NUM_LSTM(N), .SLOT_W(SW)) bus0 ();
  lstm_h_history_if #(.WIDTH(W), .NUM_LSTM(N), .SLOT_W(SW)) bus1 ();

  assign bus0.i = i_s;   assign bus1.i = i_s;
  assign bus0.wr = wr_s; assign bus1.wr = wr_s;
  assign bus0.seq_start = ss_s; assign bus1.seq_start = ss_s;
  assign bus0.bwd_start = bs_s; assign bus1.bwd_start = bs_s;
  assign bus0.rd = rd_s; assign bus1.rd = rd_s;
  assign bus0.rd_mode = rm_s; assign bus1.rd_mode = rm_s;
  assign bus0.rd_slot = slot_s; assign bus1.rd_slot = slot_s;

  lstm_h_history #(.WIDTH(W), .NUM_LSTM(N), .TIMESTEP(T), .SLOT_W(SW), .INIT(INITV), .CARRY(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  lstm_h_history #(.WIDTH(W), .NUM_LSTM(N), .TIMESTEP(T), .SLOT_W(SW), .INIT(INITV), .CARRY(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Reference model: contents as [slot][unit], write position derived from the
  // number of words written since the sequence began.
  logic [31:0] mm [2][0:T][0:N-1];
  int          nw [2];
  int          bp [2];
  bit          dn [2];
  bit          ovf [2];
  bit          mv [2];
  logic [63:0] mo [2];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit f;
      int s;
      if (rst) begin
        for (int sl = 0; sl <= T; sl++)
          for (int u = 0; u < N; u++) mm[d][sl][u] = (sl == 0) ? INITV : 32'd0;
        nw[d] = 0; bp[d] = 0; mo[d] = '0; mv[d] = 0; dn[d] = 0; ovf[d] = 0;
        continue;
      end
      f = (nw[d] == N * T);
      mv[d] = 0;
      if (rd_s) begin
        s = rm_s ? bp[d] : int'(slot_s);
        mv[d] = 1;
        mo[d] = (s > T) ? 64'd0 : {mm[d][s][1], mm[d][s][0]};
      end
      if (bs_s) begin
        bp[d] = f ? T : nw[d] / N;
        dn[d] = 0;
      end else if (rd_s && rm_s) begin
        if (bp[d] > 0) bp[d]--;
        else dn[d] = 1;
      end
      if (ss_s) begin
        dn[d] = 0;
        if (d == 1 && f)
          for (int u = 0; u < N; u++) mm[d][0][u] = mm[d][T][u];
        nw[d] = 0;
      end else if (wr_s) begin
        if (f) ovf[d] = 1;
        else begin
          mm[d][1 + nw[d] / N][nw[d] % N] = i_s;
          nw[d]++;
        end
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [63:0] o, input logic ov, input logic [SW-1:0] ts,
                           input logic f, input logic bd, input logic of);
    int exp_ts;
    exp_ts = (nw[d] == N * T) ? T : 1 + nw[d] / N;
    chk($sformatf("d%0d.o", d), o, mo[d]);
    chk($sformatf("d%0d.o_valid", d), 64'(ov), 64'(mv[d]));
    chk($sformatf("d%0d.wr_ts", d), 64'(ts), 64'(exp_ts));
    chk($sformatf("d%0d.full", d), 64'(f), 64'(nw[d] == N * T));
    chk($sformatf("d%0d.bptt_done", d), 64'(bd), 64'(dn[d]));
    chk($sformatf("d%0d.overflow", d), 64'(of), 64'(ovf[d]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_dut(0, bus0.o, bus0.o_valid, bus0.wr_ts, bus0.full, bus0.bptt_done, bus0.overflow);
    check_dut(1, bus1.o, bus1.o_valid, bus1.wr_ts, bus1.full, bus1.bptt_done, bus1.overflow);
  endtask

  task automatic idle();
    i_s = '0; wr_s = 0; ss_s = 0; bs_s = 0; rd_s = 0; rm_s = 0; slot_s = '0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic do_wr(input int v);
    i_s = v; wr_s = 1; tick(); wr_s = 0;
  endtask

  task automatic do_rd(input int s, input bit m);
    rd_s = 1; rm_s = m; slot_s = SW'(s); tick(); rd_s = 0; rm_s = 0;
  endtask

  typedef struct {
    int          slot;
    logic [63:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [6];
  logic [63:0] bwd_exp [4];

  initial begin
    tbl[0] = '{0,  INIT_VEC};
    tbl[1] = '{1,  64'h0000_0002_0000_0001};
    tbl[2] = '{3,  64'h0000_0006_0000_0005};
    tbl[3] = '{7,  64'h0000_000e_0000_000d};
    tbl[4] = '{8,  64'h0};
    tbl[5] = '{15, 64'h0};
    bwd_exp[0] = 64'h0000_0006_0000_0005;
    bwd_exp[1] = 64'h0000_0004_0000_0003;
    bwd_exp[2] = 64'h0000_0002_0000_0001;
    bwd_exp[3] = INIT_VEC;

    idle();
    rst = 1;

    // Reset state and slot-0 initial value
    do_reset();
    chk("rst_wr_ts", 64'(bus0.wr_ts), 64'd1);
    chk("rst_o_valid", 64'(bus0.o_valid), 64'd0);
    do_rd(0, 0);
    chk("rst_slot0", bus0.o, INIT_VEC);
    chk("rst_slot0_valid", 64'(bus0.o_valid), 64'd1);
    tick();
    chk("valid_pulse_drop", 64'(bus0.o_valid), 64'd0);
    chk("o_holds", bus0.o, INIT_VEC);
    do_rd(3, 0);
    chk("rst_slot3", bus0.o, 64'd0);

    // Fill, table of reads, overflow
    for (int v = 1; v <= 14; v++) do_wr(v);
    chk("fill_full", 64'(bus0.full), 64'd1);
    chk("fill_wr_ts", 64'(bus0.wr_ts), 64'd7);
    for (int k = 0; k < 6; k++) begin
      do_rd(tbl[k].slot, 0);
      chk($sformatf("tbl_rd_slot%0d", tbl[k].slot), bus0.o, tbl[k].exp);
      chk($sformatf("tbl_rd_slot%0d_carry", tbl[k].slot), bus1.o, tbl[k].exp);
    end
    do_wr(15);
    chk("ovf_set", 64'(bus0.overflow), 64'd1);
    do_rd(7, 0);
    chk("ovf_slot7_kept", bus0.o, 64'h0000_000e_0000_000d);

    // seq_start with and without carry
    ss_s = 1; tick(); ss_s = 0;
    chk("ss_wr_ts", 64'(bus1.wr_ts), 64'd1);
    chk("ss_full", 64'(bus1.full), 64'd0);
    chk("ss_ovf_kept", 64'(bus1.overflow), 64'd1);
    do_rd(0, 0);
    chk("carry_slot0", bus1.o, 64'h0000_000e_0000_000d);
    chk("nocarry_slot0", bus0.o, INIT_VEC);

    // Backward pass over a partial sequence
    do_reset();
    for (int v = 1; v <= 6; v++) do_wr(v);
    bs_s = 1; tick(); bs_s = 0;
    for (int k = 0; k < 4; k++) begin
      do_rd(0, 1);
      chk($sformatf("bwd_rd%0d", k), bus0.o, bwd_exp[k]);
      chk($sformatf("bwd_done%0d", k), 64'(bus0.bptt_done), 64'(k == 3));
    end
    do_rd(0, 1);
    chk("bwd_repeat_slot0", bus0.o, INIT_VEC);

    // Read-before-write on the same word (stale slot 2 = {4,3})
    ss_s = 1; tick(); ss_s = 0;
    do_wr(1);
    do_wr(2);
    rd_s = 1; slot_s = SW'(2); i_s = 99; wr_s = 1; tick(); rd_s = 0; wr_s = 0;
    chk("rbw_old", 64'(bus0.o[31:0]), 64'd3);
    do_rd(2, 0);
    chk("rbw_new", bus0.o, 64'h0000_0004_0000_0063);

    // Reset in the middle of a backward pass
    do_reset();
    for (int v = 1; v <= 15; v++) do_wr(v);
    bs_s = 1; tick(); bs_s = 0;
    for (int k = 0; k < 3; k++) do_rd(0, 1);
    rst = 1; rd_s = 1; rm_s = 1; tick(); rst = 0; rd_s = 0; rm_s = 0;
    chk("midrst_o", bus0.o, 64'd0);
    chk("midrst_done", 64'(bus0.bptt_done), 64'd0);
    chk("midrst_wr_ts", 64'(bus0.wr_ts), 64'd1);
    chk("midrst_full", 64'(bus0.full), 64'd0);
    chk("midrst_ovf", 64'(bus0.overflow), 64'd0);
    do_rd(0, 0);
    chk("midrst_slot0", bus0.o, INIT_VEC);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      rst    = ($urandom_range(0, 99) == 0);
      ss_s   = ($urandom_range(0, 19) == 0);
      bs_s   = ($urandom_range(0, 15) == 0);
      wr_s   = ($urandom_range(0, 1) == 1);
      rd_s   = ($urandom_range(0, 1) == 1);
      rm_s   = ($urandom_range(0, 1) == 1);
      slot_s = SW'($urandom_range(0, 15));
      i_s    = $urandom;
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lstm_h_history.md
Name: lstm_h_history

Overview:
- Parametrised hidden-state history buffer for the LSTM datapath.
- Stores h_t for NUM_LSTM units over TIMESTEP steps, plus an initial slot 0 holding h_{-1}.
- Forward pass writes one unit value per beat through auto-advancing pointers.
- Reads return a full NUM_LSTM-wide vector, either by random slot or by a backward (BPTT) pointer. CARRY mode preserves state across sequences.

Parameters:
- WIDTH, 32: bits per h value, signed fixed point.
- NUM_LSTM, 2: units per timestep (words per slot).
- TIMESTEP, 7: number of writable slots (1..TIMESTEP).
- SLOT_W, 4: slot index width; must satisfy 2^SLOT_W > TIMESTEP.
- INIT, 0: reset value of every slot-0 word.
- CARRY, 0: 1 = seq_start copies slot TIMESTEP into slot 0 when full.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- i, in, WIDTH: signed h value to write.
- wr, in, 1: write i at the current (wr_ts, wr_unit).
- seq_start, in, 1: begin a new sequence.
- bwd_start, in, 1: load the backward pointer.
- rd, in, 1: read request.
- rd_mode, in, 1: 0 = read slot rd_slot; 1 = read slot bwd_ptr.
- rd_slot, in, SLOT_W: random-read slot index.
- o, out, NUM_LSTM*WIDTH: read vector; unit 0 in the LSBs.
- o_valid, out, 1: one-cycle pulse when o is updated.
- wr_ts, out, SLOT_W: current write slot.
- full, out, 1: slots 1..TIMESTEP all written.
- bptt_done, out, 1: backward read of slot 0 has occurred.
- overflow, out, 1: sticky; set by wr while full.

Behaviour:
- Storage: NUM_LSTM*(TIMESTEP+1) words of WIDTH bits. Word address = slot*NUM_LSTM + unit.
- Reset (rst=1 at posedge): all inputs ignored that cycle.
  - Slot-0 words = INIT; all other words = 0.
  - wr_ts=1, wr_unit=0, full=0, bwd_ptr=0.
  - o=0, o_valid=0, bptt_done=0, overflow=0.
  - Reset mid-sequence or mid-BPTT aborts it completely.
- Write (wr=1, full=0):
  - mem[wr_ts*NUM_LSTM+wr_unit] <= i.
  - If wr_unit==NUM_LSTM-1: wr_unit<=0, then wr_ts++ if wr_ts<TIMESTEP, else full<=1 and wr_ts holds at TIMESTEP.
  - Otherwise wr_unit++.
- Write while full: no memory change, no wrap; overflow<=1 (sticky until rst).
- seq_start: has priority over wr, which is dropped that cycle (overflow is not set).
  - wr_ts<=1, wr_unit<=0, full<=0, bptt_done<=0. overflow unchanged.
  - CARRY=1 and full=1: slot 0 <= slot TIMESTEP, all NUM_LSTM words in one cycle. Otherwise slot 0 is unchanged.
  - Slots 1..TIMESTEP keep stale data.
- bwd_start: bwd_ptr <= TIMESTEP if full, else wr_ts-1 (the last completed slot; 0 if none). bptt_done<=0.
  - Same cycle as seq_start: bwd_start uses pre-seq_start state.
- Read: 1-cycle latency. rd at cycle n gives o and o_valid=1 at n+1; o holds otherwise.
  - rd_mode=0: o <= slot rd_slot. If rd_slot>TIMESTEP, o<=0 and o_valid still pulses.
  - rd_mode=1: o <= slot bwd_ptr. If bwd_ptr>0, decrement it; if bwd_ptr==0, set bptt_done<=1 and hold the pointer, so repeat reads return slot 0.
  - rd with bwd_start in the same cycle: read uses the old bwd_ptr.
- Read-during-write to the same word returns the old value (read-before-write). This includes a same-cycle CARRY copy into slot 0.
- Width rule: values stored and returned verbatim, with no arithmetic and no sign change.

Test Plan:
- Reset, INIT=32'h0000_1000, NUM_LSTM=2 -> rd slot 0: o=64'h0000_1000_0000_1000, o_valid one cycle later. Rd slot 3: o=0.
- 14 writes i=1..14 (TIMESTEP=7) -> full=1 after the 14th. Rd slot 7: o={14,13}. Rd slot 1: o={2,1}. 15th wr: memory unchanged, overflow=1.
- 6 writes i=1..6, bwd_start, then 4 rd_mode=1 reads -> o={6,5},{4,3},{2,1},{INIT,INIT}. bptt_done=1 after the 4th. 5th read returns slot 0 again.
- CARRY=1: full buffer with slot 7={14,13}, seq_start -> rd slot 0 = {14,13}, wr_ts=1, full=0. CARRY=0: slot 0 stays INIT.
- Same-cycle rd slot 2 and wr to unit 0 of slot 2 (old 3, new 99) -> o unit 0 = 3. Next rd slot 2 gives unit 0 = 99.
- rst asserted mid-BPTT with bwd_ptr=4 -> next cycle o=0, bptt_done=0, wr_ts=1, full=0, overflow=0, slot 0=INIT.
